// File: rtl/id_decode_stage.sv
// id_decode_stage: registered MIPS instruction-decode stage.
// Splits a 32-bit instruction into opcode/funct, register indices, an
// extended immediate (or shamt) and a region jump target, then holds the
// result in an output register behind a valid/ready handshake.
// Optional build macro: ID_DECODE_SKID_EN adds a one-entry skid register so
// in_ready comes straight from a flop instead of from out_ready.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid, once raised, is held (with stable data) until ready is
// seen. flush overrides everything: nothing is captured in a flush cycle and
// every held instruction is discarded.
module id_decode_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int SYSCALL_RA = 2,
    parameter int SYSCALL_RB = 4,
    parameter int LINK_REG   = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       code,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic              shift,
    input  logic              syscall,
    input  logic              reg_dst,
    input  logic              jal,
    input  logic              zero_ext,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [REG_AW-1:0] ra,
    output logic [REG_AW-1:0] rb,
    output logic [REG_AW-1:0] rw,
    output logic [DATA_W-1:0] extend,
    output logic [DATA_W-1:0] pc_jump,
    output logic [DATA_W-1:0] pc_out
);

    typedef struct packed {
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [REG_AW-1:0] rw;
        logic [DATA_W-1:0] extend;
        logic [DATA_W-1:0] pc_jump;
        logic [DATA_W-1:0] pc_out;
    } dec_t;

    // Low REG_AW bits of a 5-bit field, zero-padded when REG_AW is wider.
    function automatic logic [REG_AW-1:0] reg_idx(input logic [4:0] f);
        logic [REG_AW+4:0] wide;
        wide = {{REG_AW{1'b0}}, f};
        return wide[REG_AW-1:0];
    endfunction

    dec_t dec_in;
    dec_t out_q;
    logic out_valid_q;
    logic accept;

    // Combinational decode of the presented instruction.
    always_comb begin
        dec_in         = '0;
        dec_in.opcode  = code[31:26];
        dec_in.funct   = code[5:0];
        if (syscall)
            dec_in.ra = REG_AW'(SYSCALL_RA);
        else if (shift)
            dec_in.ra = reg_idx(code[20:16]);
        else
            dec_in.ra = reg_idx(code[25:21]);
        dec_in.rb = syscall ? REG_AW'(SYSCALL_RB) : reg_idx(code[20:16]);
        if (jal)
            dec_in.rw = REG_AW'(LINK_REG);
        else if (reg_dst)
            dec_in.rw = reg_idx(code[15:11]);
        else
            dec_in.rw = reg_idx(code[20:16]);
        if (shift)
            dec_in.extend = {{(DATA_W-5){1'b0}}, code[10:6]};
        else if (zero_ext)
            dec_in.extend = {{(DATA_W-16){1'b0}}, code[15:0]};
        else
            dec_in.extend = {{(DATA_W-16){code[15]}}, code[15:0]};
        // Region jump: keep the top nibble of PC+4.
        dec_in.pc_jump = {pc_plus4[DATA_W-1:28], code[25:0], 2'b00};
        dec_in.pc_out  = pc_plus4;
    end

`ifdef ID_DECODE_SKID_EN
    dec_t skid_q;
    logic skid_valid_q;
    logic load_out;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    // Output register may take new data when empty or being drained.
    assign load_out = !out_valid_q || out_ready;

    // Output plus skid: the skid drains first so order is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (load_out) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec_in;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec_in;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Single output register, replaced in place on back-to-back accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_q       <= dec_in;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign opcode    = out_q.opcode;
    assign funct     = out_q.funct;
    assign ra        = out_q.ra;
    assign rb        = out_q.rb;
    assign rw        = out_q.rw;
    assign extend    = out_q.extend;
    assign pc_jump   = out_q.pc_jump;
    assign pc_out    = out_q.pc_out;

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered instruction-decode stage for the redirect pipeline. It takes a fetched 32-bit MIPS instruction plus its PC+4 and the per-instruction control bits, and splits it into opcode, funct, register indices, extended immediate and jump target. Results are held in an output register with a valid/ready handshake. The stage supports stall, flush, a parametrised datapath width and configurable syscall/link register indices.

## Interface
Parameters:
- DATA_W, 32: width of `extend`, `pc_plus4` and `pc_jump`. Must be ≥ 32.
- REG_AW, 5: register index width. Indices are taken from the low REG_AW bits of each 5-bit instruction field, zero-padded if REG_AW > 5.
- SYSCALL_RA, 2: RA index forced during syscall.
- SYSCALL_RB, 4: RB index forced during syscall.
- LINK_REG, 31: RW index forced during jal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept the instruction this cycle.
- code  in  32  instruction word.
- pc_plus4  in  DATA_W  PC+4 of the instruction.
- shift, syscall, reg_dst, jal, zero_ext  in  1 each  control bits qualified by in_valid.
- flush  in  1  squash the held and incoming instruction (branch redirect).
- out_valid  out  1  output register holds a decoded instruction.
- out_ready  in  1  downstream consumes the output this cycle.
- opcode, funct  out  6 each  code[31:26], code[5:0].
- ra, rb, rw  out  REG_AW each  decoded register indices.
- extend  out  DATA_W  extended immediate or shamt.
- pc_jump  out  DATA_W  jump target.
- pc_out  out  DATA_W  registered pc_plus4.

## Operation
Decode is combinational from the inputs and is captured only on an accept, i.e. when in_valid && in_ready:
- **ra:** if syscall, SYSCALL_RA. Otherwise code[20:16] if shift, else code[25:21].
- **rb:** if syscall, SYSCALL_RB. Otherwise code[20:16].
- **rw:** if jal, LINK_REG. Otherwise code[15:11] if reg_dst, else code[20:16].
- **extend:**
  - shift: zero-extended code[10:6].
  - zero_ext (and not shift): zero-extended code[15:0].
  - otherwise: code[15:0] sign-extended to DATA_W.
- **pc_jump:** {pc_plus4[DATA_W-1:28], code[25:0], 2'b00}. This is the MIPS region jump and replaces the older zero-upper form.

Handshake and flush rules:
- Base handshake: in_ready = !out_valid || out_ready.
- out_valid is set on accept and cleared when out_ready is high with no new accept.
- flush has priority over everything:
  - next cycle out_valid = 0;
  - any same-cycle input is dropped;
  - in_ready is still driven per its rule, but nothing is captured.
- While out_valid && !out_ready, all output fields are held stable.

Reset (rst_n low, asynchronous):
- out_valid = 0.
- All data outputs are 0.
- in_ready reads 1 during and after reset.
- Reset asserted mid-transfer discards the held instruction.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle when out_ready is held high.
- Back-to-back accept with simultaneous out_ready replaces the output register in place.
- Flush in cycle N gives out_valid = 0 in cycle N+1, and new accepts are possible from N+1.
- in_ready is combinational from out_ready in the base configuration.

## Configuration
- Macro: `ID_DECODE_SKID_EN`.
- **Defined:** adds a one-entry skid register, and in_ready = !skid_valid, taken directly from a flop.
  - An accept while the output is stalled is stored in the skid.
  - The skid moves to the output on the next out_ready, preserving order.
  - flush clears both the output and the skid.
  - After reset skid_valid = 0.
- **Undefined:** no skid register; in_ready follows the combinational rule above.
- Decode results, latency and flush behaviour are identical in both builds.

## Test plan
- Reset, then code=0x8C220004 (shift=0, reg_dst=0, zero_ext=0) -> next cycle out_valid=1, opcode=0x23, ra=1, rb=2, rw=2, extend=0x00000004.
- code=0x2021FFFF -> extend=0xFFFFFFFF with zero_ext=0; extend=0x0000FFFF with zero_ext=1.
- code=0x00021940 with shift=1, reg_dst=1 -> ra=2, rb=2, rw=3, extend=0x00000005, funct=0. Repeat with syscall=1 -> ra=2, rb=4.
- code=0x0C000010, pc_plus4=0x80000004, jal=1 -> pc_jump=0x80000040, rw=31, pc_out=0x80000004.
- Stall and flush sequence:
  - Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, at most one extra instruction accepted (skid build only), none lost or reordered once out_ready=1.
  - Assert flush -> out_valid=0 next cycle.
- Drop rst_n asynchronously mid-cycle while out_valid=1 -> out_valid and all fields 0 immediately, in_ready=1.
